arm_cond_pipe: RTL and testbench

Parametrised control-signal pipeline for the pipelined ARM core, sitting between the decoder (D stage) and the datapath's E/M/W stages. It carries the decoded control bits D→E→M→W, holds the NZCV flags register, evaluates the ARM condition field in E, and gates every side-effecting control bit with the condition result. Compared with the earlier hard-wired E-stage control registers, it adds:

- an E-stage stall/flush handshake;
- a configurable number of memory stages;
- early branch-taken resolution in E;
- a saturating counter of condition-failed instructions.

---
 rtl/arm_cond_pipe_pkg.sv | 73 +++++++
 rtl/arm_cond_pipe_if.sv | 11 +
 rtl/arm_cond_pipe_condcheck.sv | 10 +
 rtl/arm_cond_pipe.sv | 168 ++++++++++++++++
 tb/tb_arm_cond_pipe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_cond_pipe_pkg.sv
// Shared types for the ARM condition/control pipeline: the condition-code enum,
// the per-stage control record and the condition evaluator.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // One record type for every stage register; a bubble is all zeros.
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       pcsrc;
        logic       branch;
        logic       bl;
        logic [1:0] flagwrite;
        logic [3:0] cond;
    } ctrl_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond_e'(cond))
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arm_cond_pipe_if.sv
// Condition-check bundle: the E-stage condition field, flags and valid bit going
// into the checker, and the pass result coming back.
interface arm_cond_pipe_if;
    logic [3:0] cond;
    logic [3:0] flags;
    logic       valid;
    logic       cond_ex;

    modport master (output cond, output flags, output valid, input cond_ex);
    modport slave  (input cond, input flags, input valid, output cond_ex);
endinterface

// File: rtl/arm_cond_pipe_condcheck.sv
// Combinational ARM condition checker for the instruction currently in E.
module arm_condcheck
    import arm_ctrl_pkg::*;
(
    arm_cond_pipe_if.slave cif
);

    assign cif.cond_ex = cif.valid & cond_eval(cif.cond, cif.flags);

endmodule

// File: rtl/arm_cond_pipe.sv
// Control-signal pipeline D->E->M1..Mn->W with NZCV flags, E-stage condition
// gating, stall/flush on E, early branch resolution and a squash counter.
module arm_cond_pipe
    import arm_ctrl_pkg::*;
#(
    parameter int         MEM_LAT   = 1,
    parameter int         CNT_W     = 16,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             BranchD,
    input  logic             BLD,
    input  logic [1:0]       FlagWriteD,
    input  logic [3:0]       ALUFlagsE,
    output logic [3:0]       FlagsE,
    output logic             CondExE,
    output logic             BranchTakenE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemtoRegM,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             PCSrcW,
    output logic             BLW,
    output logic [CNT_W-1:0] SquashCount
);

    ctrl_t            e_q, e_d;
    ctrl_t            m1_d;
    ctrl_t            m_q [MEM_LAT];
    ctrl_t            w_q;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cond_ex;
    logic             advance;

    // E leaves to M1 only on an edge where it is neither held nor flushed.
    assign advance = ~StallE & ~FlushE;

    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (!StallE) begin
            e_d.valid     = 1'b1;
            e_d.regwrite  = RegWriteD;
            e_d.memwrite  = MemWriteD;
            e_d.memtoreg  = MemtoRegD;
            e_d.pcsrc     = PCSrcD;
            e_d.branch    = BranchD;
            e_d.bl        = BLD;
            e_d.flagwrite = FlagWriteD;
            e_d.cond      = CondD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    arm_cond_pipe_if cc_if ();

    assign cc_if.cond  = e_q.cond;
    assign cc_if.flags = flags_q;
    assign cc_if.valid = e_q.valid;
    assign cond_ex     = cc_if.cond_ex;

    arm_condcheck u_condcheck (
        .cif (cc_if.slave)
    );

    // Side-effecting bits are gated here; MemtoReg is harmless without RegWrite.
    always_comb begin
        m1_d = '0;
        if (advance && e_q.valid) begin
            m1_d.valid    = 1'b1;
            m1_d.regwrite = e_q.regwrite & cond_ex;
            m1_d.memwrite = e_q.memwrite & cond_ex;
            m1_d.memtoreg = e_q.memtoreg;
            m1_d.pcsrc    = e_q.pcsrc & cond_ex;
            m1_d.bl       = e_q.bl & cond_ex;
        end
    end

    generate
        for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_mem
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        m_q[gi] <= '0;
                    end else begin
                        m_q[gi] <= m1_d;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) begin
                        m_q[gi] <= '0;
                    end else begin
                        m_q[gi] <= m_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q <= '0;
        end else begin
            w_q <= m_q[MEM_LAT-1];
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (advance && cond_ex) begin
            if (e_q.flagwrite[1]) flags_d[FLAG_N:FLAG_Z] = ALUFlagsE[FLAG_N:FLAG_Z];
            if (e_q.flagwrite[0]) flags_d[FLAG_C:FLAG_V] = ALUFlagsE[FLAG_C:FLAG_V];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (advance && e_q.valid && !cond_ex && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign FlagsE       = flags_q;
    assign CondExE      = cond_ex;
    assign BranchTakenE = e_q.branch & cond_ex;
    assign RegWriteM    = m_q[0].regwrite;
    assign MemWriteM    = m_q[0].memwrite;
    assign MemtoRegM    = m_q[0].memtoreg;
    assign RegWriteW    = w_q.regwrite;
    assign MemtoRegW    = w_q.memtoreg;
    assign PCSrcW       = w_q.pcsrc;
    assign BLW          = w_q.bl;
    assign SquashCount  = cnt_q;

    // W carries the full record, but only some fields leave the block.
    logic unused_w_bits;
    assign unused_w_bits = ^{w_q.valid, w_q.memwrite, w_q.branch, w_q.flagwrite, w_q.cond};

endmodule

// File: tb/tb_arm_cond_pipe.sv
// Directed bench for arm_cond_pipe (MEM_LAT=2, CNT_W=4, FLAGS_RST=0010) plus a
// small table check of the condition checker through its interface.
module tb_arm_cond_pipe;
    import arm_ctrl_pkg::*;

    localparam int         MEM_LAT   = 2;
    localparam int         CNT_W     = 4;
    localparam logic [3:0] FLAGS_RST = 4'b0010;

    logic             clk;
    logic             reset;
    logic             StallE;
    logic             FlushE;
    logic [3:0]       CondD;
    logic             RegWriteD;
    logic             MemWriteD;
    logic             MemtoRegD;
    logic             PCSrcD;
    logic             BranchD;
    logic             BLD;
    logic [1:0]       FlagWriteD;
    logic [3:0]       ALUFlagsE;
    logic [3:0]       FlagsE;
    logic             CondExE;
    logic             BranchTakenE;
    logic             RegWriteM;
    logic             MemWriteM;
    logic             MemtoRegM;
    logic             RegWriteW;
    logic             MemtoRegW;
    logic             PCSrcW;
    logic             BLW;
    logic [CNT_W-1:0] SquashCount;

    int checks_total;
    int checks_passed;

    arm_cond_pipe #(
        .MEM_LAT   (MEM_LAT),
        .CNT_W     (CNT_W),
        .FLAGS_RST (FLAGS_RST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .CondD        (CondD),
        .RegWriteD    (RegWriteD),
        .MemWriteD    (MemWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .BranchD      (BranchD),
        .BLD          (BLD),
        .FlagWriteD   (FlagWriteD),
        .ALUFlagsE    (ALUFlagsE),
        .FlagsE       (FlagsE),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .PCSrcW       (PCSrcW),
        .BLW          (BLW),
        .SquashCount  (SquashCount)
    );

    arm_cond_pipe_if cc_if ();
    arm_condcheck u_cc (
        .cif (cc_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-22s got=%0h", tag, got);
        end else begin
            $display("FAIL %-22s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] cond, input logic rw, input logic mw,
                         input logic m2r, input logic pcs, input logic br,
                         input logic bl, input logic [1:0] fw);
        CondD      = cond;
        RegWriteD  = rw;
        MemWriteD  = mw;
        MemtoRegD  = m2r;
        PCSrcD     = pcs;
        BranchD    = br;
        BLD        = bl;
        FlagWriteD = fw;
    endtask

    // A no-op is a valid AL instruction with no side effects.
    task automatic nop_d();
        set_d(4'hE, 0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       valid;
        logic       exp;
    } cc_vec_t;

    cc_vec_t cc_tab [10];

    initial begin
        checks_total  = 0;
        checks_passed = 0;

        cc_tab[0] = '{4'h8, 4'b0010, 1'b1, 1'b1}; // HI: C=1 Z=0
        cc_tab[1] = '{4'h8, 4'b0110, 1'b1, 1'b0}; // HI: Z=1
        cc_tab[2] = '{4'h9, 4'b0000, 1'b1, 1'b1}; // LS: C=0
        cc_tab[3] = '{4'hA, 4'b1001, 1'b1, 1'b1}; // GE: N=V=1
        cc_tab[4] = '{4'hB, 4'b1000, 1'b1, 1'b1}; // LT: N!=V
        cc_tab[5] = '{4'hC, 4'b1101, 1'b1, 1'b0}; // GT: Z=1
        cc_tab[6] = '{4'hD, 4'b0001, 1'b1, 1'b1}; // LE: N!=V
        cc_tab[7] = '{4'h4, 4'b0000, 1'b1, 1'b0}; // MI: N=0
        cc_tab[8] = '{4'h6, 4'b0001, 1'b1, 1'b1}; // VS: V=1
        cc_tab[9] = '{4'hE, 4'b1111, 1'b0, 1'b0}; // AL but invalid

        for (int i = 0; i < 10; i++) begin
            cc_if.cond  = cc_tab[i].cond;
            cc_if.flags = cc_tab[i].flags;
            cc_if.valid = cc_tab[i].valid;
            #1;
            check_val($sformatf("condcheck[%0d]", i), {31'd0, cc_if.cond_ex}, {31'd0, cc_tab[i].exp});
        end

        reset     = 1'b1;
        StallE    = 1'b0;
        FlushE    = 1'b0;
        ALUFlagsE = 4'b0000;
        nop_d();
        tick();
        tick();
        check_val("rst_flags", {28'd0, FlagsE}, {28'd0, FLAGS_RST});
        check_val("rst_condex", {31'd0, CondExE}, 32'd0);
        check_val("rst_regwm", {31'd0, RegWriteM}, 32'd0);
        check_val("rst_regww", {31'd0, RegWriteW}, 32'd0);
        check_val("rst_squash", {28'd0, SquashCount}, 32'd0);
        reset = 1'b0;

        // Flag write, then EQ sees the new Z.
        set_d(4'hE, 0, 0, 0, 0, 0, 0, 2'b11);
        ALUFlagsE = 4'b0100;
        tick();
        check_val("fw_condex", {31'd0, CondExE}, 32'd1);
        set_d(4'h0, 1, 0, 0, 0, 0, 0, 2'b00);
        tick();
        check_val("fw_flags", {28'd0, FlagsE}, 32'h4);
        check_val("eq_condex", {31'd0, CondExE}, 32'd1);
        nop_d();
        tick();
        check_val("eq_regwm", {31'd0, RegWriteM}, 32'd1);
        tick();
        tick();
        check_val("eq_regww", {31'd0, RegWriteW}, 32'd1);
        tick();
        check_val("eq_regww_once", {31'd0, RegWriteW}, 32'd0);

        // NE with Z set fails and is squashed.
        set_d(4'h1, 1, 1, 0, 0, 0, 0, 2'b00);
        tick();
        check_val("ne_condex", {31'd0, CondExE}, 32'd0);
        nop_d();
        tick();
        check_val("ne_regwm", {31'd0, RegWriteM}, 32'd0);
        check_val("ne_memwm", {31'd0, MemWriteM}, 32'd0);
        check_val("ne_squash", {28'd0, SquashCount}, 32'd1);

        // Taken branch, then an NV branch.
        set_d(4'hE, 0, 0, 0, 1, 1, 0, 2'b00);
        tick();
        check_val("br_taken", {31'd0, BranchTakenE}, 32'd1);
        nop_d();
        tick();
        tick();
        tick();
        check_val("br_pcsrcw", {31'd0, PCSrcW}, 32'd1);
        set_d(4'hF, 0, 0, 0, 1, 1, 0, 2'b00);
        tick();
        check_val("nv_taken", {31'd0, BranchTakenE}, 32'd0);
        nop_d();
        tick();
        tick();
        tick();
        check_val("nv_pcsrcw", {31'd0, PCSrcW}, 32'd0);
        check_val("nv_squash", {28'd0, SquashCount}, 32'd2);

        // Stall a flag-writing instruction for two cycles.
        set_d(4'hE, 1, 0, 1, 0, 0, 0, 2'b11);
        ALUFlagsE = 4'b1001;
        tick();
        StallE = 1'b1;
        nop_d();
        tick();
        check_val("stall1_m2rm", {31'd0, MemtoRegM}, 32'd0);
        check_val("stall1_flags", {28'd0, FlagsE}, 32'h4);
        tick();
        check_val("stall2_regwm", {31'd0, RegWriteM}, 32'd0);
        check_val("stall2_flags", {28'd0, FlagsE}, 32'h4);
        StallE = 1'b0;
        tick();
        check_val("rel_flags", {28'd0, FlagsE}, 32'h9);
        check_val("rel_regwm", {31'd0, RegWriteM}, 32'd1);
        ALUFlagsE = 4'b0000;
        tick();
        check_val("rel_flags_once", {28'd0, FlagsE}, 32'h9);
        check_val("rel_regwm_once", {31'd0, RegWriteM}, 32'd0);
        tick();
        check_val("stall_regww", {31'd0, RegWriteW}, 32'd1);
        check_val("stall_m2rw", {31'd0, MemtoRegW}, 32'd1);
        tick();
        check_val("stall_regww_once", {31'd0, RegWriteW}, 32'd0);

        // Flush and stall together on a failing instruction.
        set_d(4'h0, 1, 0, 0, 0, 0, 0, 2'b11);
        ALUFlagsE = 4'b0110;
        tick();
        check_val("fl_condex_pre", {31'd0, CondExE}, 32'd0);
        FlushE = 1'b1;
        StallE = 1'b1;
        nop_d();
        tick();
        check_val("fl_condex", {31'd0, CondExE}, 32'd0);
        check_val("fl_flags", {28'd0, FlagsE}, 32'h9);
        check_val("fl_squash", {28'd0, SquashCount}, 32'd2);
        FlushE = 1'b0;
        StallE = 1'b0;
        tick();
        check_val("fl_regwm", {31'd0, RegWriteM}, 32'd0);
        check_val("fl_squash_after", {28'd0, SquashCount}, 32'd2);

        // Saturation: 17 NV instructions on top of a count of 2.
        set_d(4'hF, 1, 0, 0, 0, 0, 0, 2'b00);
        for (int i = 0; i < 13; i++) tick();
        check_val("sat_mid", {28'd0, SquashCount}, 32'd14);
        for (int i = 0; i < 4; i++) tick();
        nop_d();
        tick();
        check_val("sat_final", {28'd0, SquashCount}, 32'd15);
        check_val("sat_flags", {28'd0, FlagsE}, 32'h9);

        // Reset mid-stream with a write in flight.
        set_d(4'hE, 1, 1, 0, 1, 0, 1, 2'b00);
        tick();
        nop_d();
        tick();
        check_val("pre_rst_regwm", {31'd0, RegWriteM}, 32'd1);
        reset = 1'b1;
        tick();
        check_val("mid_rst_flags", {28'd0, FlagsE}, {28'd0, FLAGS_RST});
        check_val("mid_rst_squash", {28'd0, SquashCount}, 32'd0);
        check_val("mid_rst_regwm", {31'd0, RegWriteM}, 32'd0);
        check_val("mid_rst_memwm", {31'd0, MemWriteM}, 32'd0);
        check_val("mid_rst_condex", {31'd0, CondExE}, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check_val("post_rst_regww", {31'd0, RegWriteW}, 32'd0);
        check_val("post_rst_blw", {31'd0, BLW}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
